// File: rtl/score_keeper_if.sv
// Pong match-controller bus: button/point inputs in, scores, ball gating and win levels out.
interface score_keeper_if #(
  parameter int SCORE_W = 4
);
  logic               start;
  logic               point_left;
  logic               point_right;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic               ball_en;
  logic               serve;
  logic               left;
  logic               right;

  modport master (
    output start, point_left, point_right,
    input  score_left, score_right, ball_en, serve, left, right
  );

  modport slave (
    input  start, point_left, point_right,
    output score_left, score_right, ball_en, serve, left, right
  );
endinterface

// File: rtl/score_keeper.sv
// Pong match controller: scores, serve delay and held win levels, all outputs registered.
// Points and start act at the edge that samples them; no backpressure, pulses outside PLAY are dropped.
module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input  logic          clock,
  input  logic          reset,
  score_keeper_if.slave sk
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] WIN_L = 3'd3;
  localparam logic [2:0] WIN_R = 3'd4;

  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_CYCLES - 1);

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               ball_en_q;
  logic               serve_q;
  logic               left_q;
  logic               right_q;
  logic               start_q;

  logic               start_rise;
  logic [SCORE_W-1:0] score_l_inc;
  logic [SCORE_W-1:0] score_r_inc;

  assign start_rise  = sk.start & ~start_q;
  assign score_l_inc = score_l + SCORE_W'(1);
  assign score_r_inc = score_r + SCORE_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      score_l   <= '0;
      score_r   <= '0;
      ball_en_q <= 1'b0;
      serve_q   <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      start_q <= sk.start;
      serve_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise) begin
            state <= SERVE;
            cnt   <= '0;
          end
        end
        SERVE: begin
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            serve_q   <= 1'b1;
            ball_en_q <= 1'b1;
            state     <= PLAY;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PLAY: begin
          // Simultaneous points cancel: neither player is credited.
          if (sk.point_left && !sk.point_right) begin
            score_l   <= score_l_inc;
            ball_en_q <= 1'b0;
            if (score_l_inc == WIN_VAL) begin
              left_q <= 1'b1;
              state  <= WIN_L;
            end else begin
              cnt   <= '0;
              state <= SERVE;
            end
          end else if (sk.point_right && !sk.point_left) begin
            score_r   <= score_r_inc;
            ball_en_q <= 1'b0;
            if (score_r_inc == WIN_VAL) begin
              right_q <= 1'b1;
              state   <= WIN_R;
            end else begin
              cnt   <= '0;
              state <= SERVE;
            end
          end
        end
        WIN_L, WIN_R: begin
          if (start_rise) begin
            score_l <= '0;
            score_r <= '0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            cnt     <= '0;
            state   <= SERVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sk.score_left  = score_l;
  assign sk.score_right = score_r;
  assign sk.ball_en     = ball_en_q;
  assign sk.serve       = serve_q;
  assign sk.left        = left_q;
  assign sk.right       = right_q;
endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper with WIN_SCORE=3, SERVE_CYCLES=4: directed match sequence against a match-level model.
module tb_score_keeper;
  localparam int WIN_SCORE    = 3;
  localparam int SCORE_W      = 4;
  localparam int SERVE_CYCLES = 4;
  localparam int CNT_W        = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  score_keeper_if #(.SCORE_W(SCORE_W)) sk ();

  score_keeper #(
    .WIN_SCORE    (WIN_SCORE),
    .SCORE_W      (SCORE_W),
    .SERVE_CYCLES (SERVE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sk    (sk)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Match model: a countdown of serve cycles still to wait, a winner id and an idle flag.
  int m_sl = 0, m_sr = 0, m_winner = 0, m_wait = 0;
  bit m_idle = 1'b1, m_prev = 1'b0, m_serve = 1'b0, m_rise;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_sl = 0; m_sr = 0; m_winner = 0; m_wait = 0;
      m_idle = 1'b1; m_prev = 1'b0; m_serve = 1'b0;
    end else begin
      m_rise  = sk.start && !m_prev;
      m_prev  = sk.start;
      m_serve = 1'b0;
      if (m_idle) begin
        if (m_rise) begin m_idle = 1'b0; m_wait = SERVE_CYCLES; end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_serve = 1'b1;
      end else if (m_winner != 0) begin
        if (m_rise) begin m_sl = 0; m_sr = 0; m_winner = 0; m_wait = SERVE_CYCLES; end
      end else if (sk.point_left != sk.point_right) begin
        if (sk.point_left) begin
          m_sl++;
          if (m_sl == WIN_SCORE) m_winner = 1; else m_wait = SERVE_CYCLES;
        end else begin
          m_sr++;
          if (m_sr == WIN_SCORE) m_winner = 2; else m_wait = SERVE_CYCLES;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("cmp_score_left",  int'(sk.score_left),  m_sl);
    chk("cmp_score_right", int'(sk.score_right), m_sr);
    chk("cmp_serve",       int'(sk.serve),       int'(m_serve));
    chk("cmp_ball_en",     int'(sk.ball_en),     int'(!m_idle && m_wait == 0 && m_winner == 0));
    chk("cmp_left",        int'(sk.left),        int'(m_winner == 1));
    chk("cmp_right",       int'(sk.right),       int'(m_winner == 2));
  end

  task automatic point(input bit l, input bit r);
    sk.point_left  = l;
    sk.point_right = r;
    @(negedge clock);
    sk.point_left  = 1'b0;
    sk.point_right = 1'b0;
  endtask

  task automatic wait_serve(input string nm, input int exp);
    int k;
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (sk.serve) begin k = i; break; end
    end
    chk(nm, k, exp);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_score_left"},  int'(sk.score_left),  0);
    chk({nm, "_score_right"}, int'(sk.score_right), 0);
    chk({nm, "_ball_en"},     int'(sk.ball_en),     0);
    chk({nm, "_serve"},       int'(sk.serve),       0);
    chk({nm, "_left"},        int'(sk.left),        0);
    chk({nm, "_right"},       int'(sk.right),       0);
  endtask

  initial begin
    int first, npulse;
    sk.start = 1'b0; sk.point_left = 1'b0; sk.point_right = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);

    // Held start: exactly one serve, four cycles after the sampling edge.
    sk.start = 1'b1;
    first = -1; npulse = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (sk.serve) begin npulse++; if (first < 0) first = k; end
    end
    sk.start = 1'b0;
    chk("start_serve_delay", first, 4);
    chk("start_serve_count", npulse, 1);
    chk("start_ball_en", int'(sk.ball_en), 1);

    point(1'b1, 1'b0);
    chk("pl_score_left", int'(sk.score_left), 1);
    chk("pl_ball_en", int'(sk.ball_en), 0);
    wait_serve("pl_serve_delay", 4);

    point(1'b0, 1'b1); wait_serve("s11_serve", 4);
    point(1'b0, 1'b1); wait_serve("s12_serve", 4);
    point(1'b1, 1'b0); wait_serve("s22_serve", 4);
    chk("s22_left", int'(sk.score_left), 2);
    chk("s22_right", int'(sk.score_right), 2);
    point(1'b0, 1'b1);
    chk("winr_score_right", int'(sk.score_right), 3);
    chk("winr_right", int'(sk.right), 1);
    chk("winr_left", int'(sk.left), 0);
    chk("winr_ball_en", int'(sk.ball_en), 0);
    for (int i = 0; i < 20; i++) begin point(1'b1, 1'b0); @(negedge clock); end
    chk("winr_frozen_left", int'(sk.score_left), 2);
    chk("winr_held_right", int'(sk.right), 1);

    sk.start = 1'b1;
    @(negedge clock);
    sk.start = 1'b0;
    chk("restart_score_left", int'(sk.score_left), 0);
    chk("restart_score_right", int'(sk.score_right), 0);
    chk("restart_right", int'(sk.right), 0);
    wait_serve("restart_serve", 4);

    point(1'b1, 1'b1);
    chk("both_score_left", int'(sk.score_left), 0);
    chk("both_score_right", int'(sk.score_right), 0);
    chk("both_ball_en", int'(sk.ball_en), 1);
    repeat (3) @(negedge clock);
    chk("both_still_play", int'(sk.ball_en), 1);

    point(1'b1, 1'b0);
    @(negedge clock);
    point(1'b0, 1'b1);
    chk("serve_ignores_point", int'(sk.score_right), 0);
    wait_serve("serve_ignores_delay", 2);

    // Asynchronous reset in the middle of a serve delay.
    point(1'b0, 1'b1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_serve");
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (6) @(negedge clock);
    chk_all_zero("idle_after_rst");

    sk.start = 1'b1;
    @(negedge clock);
    sk.start = 1'b0;
    wait_serve("rst1_serve", 4);
    point(1'b1, 1'b0); wait_serve("r10_serve", 4);
    point(1'b1, 1'b0); wait_serve("r20_serve", 4);
    point(1'b0, 1'b1); wait_serve("r21_serve", 4);
    chk("r21_left", int'(sk.score_left), 2);
    chk("r21_right", int'(sk.score_right), 1);
    chk("r21_ball_en", int'(sk.ball_en), 1);

    // Asynchronous reset during a rally at 2-1.
    #3 reset = 1'b1;
    #1 chk_all_zero("rst_play");
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (6) @(negedge clock);
    chk_all_zero("idle_after_rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
